// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: form codes,
// the per-stage record and the instruction-field decode helper.
package imm_pkg;

  localparam logic [2:0] IMM_DP_ROT = 3'b000;
  localparam logic [2:0] IMM_MEM12  = 3'b001;
  localparam logic [2:0] IMM_BR     = 3'b010;
  localparam logic [2:0] IMM_MEMH   = 3'b011;
  localparam logic [2:0] IMM_DP_RAW = 3'b100;

  localparam int IMM_XLEN_DEFAULT = 32;

  // value is always 32 bits; BR keeps its sign in bit 31 for later extension
  typedef struct packed {
    logic        valid;
    logic [2:0]  mode;
    logic [31:0] value;
    logic [3:0]  rot;
    logic        carry;
    logic        illegal;
  } imm_stage_t;

  function automatic imm_stage_t imm_decode(input logic [2:0]  src,
                                            input logic [23:0] instr,
                                            input logic        cin);
    imm_stage_t r;
    r         = '0;
    r.valid   = 1'b1;
    r.mode    = src;
    r.carry   = cin;
    case (src)
      IMM_DP_ROT: begin
        r.value = {24'h000000, instr[7:0]};
        r.rot   = instr[11:8];
      end
      IMM_MEM12:  r.value = {20'h00000, instr[11:0]};
      IMM_BR:     r.value = {{6{instr[23]}}, instr[23:0], 2'b00};
      IMM_MEMH:   r.value = {24'h000000, instr[11:8], instr[3:0]};
      IMM_DP_RAW: r.value = {24'h000000, instr[7:0]};
      default:    r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-stage bus between the pipeline/hazard logic (master) and the
// immediate generator (slave).
interface imm_extend_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN = IMM_XLEN_DEFAULT
);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [23:0]     Instr;
  logic [2:0]      ImmSrc;
  logic            CarryIn;
  logic            out_valid;
  logic [XLEN-1:0] ExtImm;
  logic            ImmCarry;
  logic            ImmIllegal;

  modport master (
    output in_valid, stall, flush, Instr, ImmSrc, CarryIn,
    input  out_valid, ExtImm, ImmCarry, ImmIllegal
  );

  modport slave (
    input  in_valid, stall, flush, Instr, ImmSrc, CarryIn,
    output out_valid, ExtImm, ImmCarry, ImmIllegal
  );
endinterface

// File: rtl/imm_extend_pipe_rotator.sv
// 32-bit rotate-right by twice the 4-bit rotate field, with the
// data-processing shifter carry-out.
module imm_rotator (
  input  logic [31:0] value_i,
  input  logic [3:0]  rot_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic        carry_o
);
  logic [4:0] amt_s;

  // a shift by 32 yields zero, so rot = 0 degenerates to a pass-through
  always_comb begin
    amt_s    = {rot_i, 1'b0};
    result_o = (value_i >> amt_s) | (value_i << (6'd32 - {1'b0, amt_s}));
    if (rot_i != 4'd0) begin
      carry_o = result_o[31];
    end else begin
      carry_o = carry_i;
    end
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: decode, optional pre-rotation stage,
// rotation/carry selection and a registered output stage.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = IMM_XLEN_DEFAULT,
  parameter int STAGES = 1
) (
  input logic         clk,
  input logic         reset,
  imm_extend_pipe_if.slave bus
);

  generate
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $error("imm_extend_pipe: STAGES must be 1 or 2");
    end
    if (XLEN < 32) begin : g_bad_xlen
      $error("imm_extend_pipe: XLEN must be at least 32");
    end
  endgenerate

  imm_stage_t      front_s;
  imm_stage_t      rot_src_s;
  logic [31:0]     rot_res_s;
  logic            rot_carry_s;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] ext_d, ext_q;
  logic            carry_d, carry_q;
  logic            illegal_d, illegal_q;

  // bubbles carry all-zero data so invalid stages never expose stale values
  always_comb begin
    if (bus.in_valid) begin
      front_s = imm_decode(bus.ImmSrc, bus.Instr, bus.CarryIn);
    end else begin
      front_s = '0;
    end
  end

  generate
    if (STAGES == 2) begin : g_two
      imm_stage_t a_q;

      // stage A holds the decoded, not yet rotated record
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
        end else if (bus.flush) begin
          a_q <= '0;
        end else if (bus.stall) begin
          a_q <= a_q;
        end else begin
          a_q <= front_s;
        end
      end

      assign rot_src_s = a_q;
    end else begin : g_one
      assign rot_src_s = front_s;
    end
  endgenerate

  imm_rotator u_rot (
    .value_i  (rot_src_s.value),
    .rot_i    (rot_src_s.rot),
    .carry_i  (rot_src_s.carry),
    .result_o (rot_res_s),
    .carry_o  (rot_carry_s)
  );

  // only the branch offset is signed; every other form zero-extends
  always_comb begin
    out_valid_d = rot_src_s.valid;
    ext_d       = '0;
    carry_d     = 1'b0;
    illegal_d   = 1'b0;
    if (rot_src_s.valid) begin
      if (rot_src_s.mode == IMM_BR) begin
        ext_d = XLEN'($signed(rot_res_s));
      end else begin
        ext_d = XLEN'(rot_res_s);
      end
      carry_d   = rot_carry_s;
      illegal_d = rot_src_s.illegal;
    end else begin
      ext_d     = '0;
      carry_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  // output stage; flush beats stall so a killed entry never lingers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.stall) begin
      out_valid_q <= out_valid_q;
      ext_q       <= ext_q;
      carry_q     <= carry_q;
      illegal_q   <= illegal_q;
    end else begin
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      carry_q     <= carry_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.ExtImm     = ext_q;
  assign bus.ImmCarry   = carry_q;
  assign bus.ImmIllegal = illegal_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: one shared directed stream drives four instances
// (STAGES 1/2 x XLEN 32/64); each instance has its own expected queue.
module tb_imm_extend_pipe;

  typedef struct {
    logic [2:0]  src;
    logic [23:0] instr;
    logic        cin;
    logic [63:0] exp;
    logic        c;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] val;
    logic        carry;
    logic        ill;
    int          stamp;
  } exp_t;

  localparam int NVEC = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [23:0] instr;
  logic [2:0]  src;
  logic        cin;
  logic [63:0] exp_val;
  logic        exp_c;
  logic        exp_ill;

  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   adv_cnt = 0;
  bit   last_stall = 1'b0;
  bit   done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    last_stall <= !reset && !flush && stall;
    if (!reset && !flush && !stall) adv_cnt <= adv_cnt + 1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int STG = (g % 2) + 1;
    localparam int XL  = (g < 2) ? 32 : 64;

    imm_extend_pipe_if #(.XLEN(XL)) bus ();
    exp_t         q[$];
    logic [XL+2:0] snap;

    assign bus.in_valid = in_valid;
    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.Instr    = instr;
    assign bus.ImmSrc   = src;
    assign bus.CarryIn  = cin;

    imm_extend_pipe #(.XLEN(XL), .STAGES(STG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    always @(posedge clk) begin
      if (reset || flush) q.delete();
      else if (!stall && in_valid) q.push_back('{exp_val, exp_c, exp_ill, adv_cnt});
    end

    always @(negedge clk) begin
      exp_t e;
      if (last_stall) begin
        checks++;
        if ({bus.out_valid, bus.ExtImm, bus.ImmCarry, bus.ImmIllegal} !== snap) begin
          errors++;
          $display("FAIL freeze inst%0d: got %h required %h", g,
                   {bus.out_valid, bus.ExtImm, bus.ImmCarry, bus.ImmIllegal}, snap);
        end
      end else if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out inst%0d: got out_valid=1 ExtImm=%h required out_valid=0",
                   g, bus.ExtImm);
        end else begin
          e = q.pop_front();
          if (bus.ExtImm !== e.val[XL-1:0] || bus.ImmCarry !== e.carry ||
              bus.ImmIllegal !== e.ill || (adv_cnt - e.stamp) != STG) begin
            errors++;
            $display("FAIL result inst%0d: got imm=%h c=%b ill=%b lat=%0d required imm=%h c=%b ill=%b lat=%0d",
                     g, bus.ExtImm, bus.ImmCarry, bus.ImmIllegal, adv_cnt - e.stamp,
                     e.val[XL-1:0], e.carry, e.ill, STG);
          end
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ExtImm !== '0 || bus.ImmCarry !== 1'b0 ||
            bus.ImmIllegal !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero inst%0d: got v=%b imm=%h c=%b ill=%b required all 0",
                   g, bus.out_valid, bus.ExtImm, bus.ImmCarry, bus.ImmIllegal);
        end
      end
      snap <= {bus.out_valid, bus.ExtImm, bus.ImmCarry, bus.ImmIllegal};
    end

    initial begin
      wait (done);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drained inst%0d: got %0d pending required 0", g, q.size());
      end
    end
  end

  task automatic apply(input int i);
    in_valid = 1'b1;
    src      = vecs[i].src;
    instr    = vecs[i].instr;
    cin      = vecs[i].cin;
    exp_val  = vecs[i].exp;
    exp_c    = vecs[i].c;
    exp_ill  = vecs[i].ill;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    src      = 3'b000;
    instr    = 24'h000000;
    cin      = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 24'h0004FF, 1'b0, 64'h00000000FF000000, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 24'h000080, 1'b1, 64'h0000000000000080, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 24'h000080, 1'b0, 64'h0000000000000080, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 24'h000123, 1'b1, 64'h0000000000000123, 1'b1, 1'b0};
    vecs[4]  = '{3'b010, 24'hFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 24'h000A35, 1'b1, 64'h00000000000000A5, 1'b1, 1'b0};
    vecs[6]  = '{3'b111, 24'hFFFFFF, 1'b1, 64'h0000000000000000, 1'b1, 1'b1};
    vecs[7]  = '{3'b100, 24'h000F7C, 1'b0, 64'h000000000000007C, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 24'h000103, 1'b0, 64'h00000000C0000000, 1'b1, 1'b0};
    vecs[9]  = '{3'b000, 24'h000F01, 1'b1, 64'h0000000000000004, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 24'h000010, 1'b1, 64'h0000000000000040, 1'b1, 1'b0};
    vecs[11] = '{3'b101, 24'h000123, 1'b0, 64'h0000000000000000, 1'b0, 1'b1};
    vecs[12] = '{3'b001, 24'hFABFFF, 1'b0, 64'h0000000000000FFF, 1'b0, 1'b0};
    vecs[13] = '{3'b011, 24'h00F0FF, 1'b1, 64'h000000000000000F, 1'b1, 1'b0};
    vecs[14] = '{3'b110, 24'h000000, 1'b1, 64'h0000000000000000, 1'b1, 1'b1};
    vecs[15] = '{3'b000, 24'h000C01, 1'b0, 64'h0000000000000100, 1'b0, 1'b0};

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    exp_val = 64'h0;
    exp_c   = 1'b0;
    exp_ill = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(i);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    // entry in flight, then 3 stalled cycles with the next input held
    apply(0);
    @(negedge clk);
    apply(4);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);

    // flush together with stall kills everything in flight
    apply(8);
    @(negedge clk);
    apply(5);
    @(negedge clk);
    idle();
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-stream with two entries in flight, then restart at once
    apply(3);
    @(negedge clk);
    apply(9);
    @(negedge clk);
    apply(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(10);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);

    done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator for the pipelined ARM datapath. It replaces the single-cycle combinational extender in the Decode stage. It adds the architectural rotated data-processing immediate with shifter carry-out, the halfword-offset form, illegal-encoding detection, and 1- or 2-stage registered output with stall/flush control matching the pipeline hazard unit.

## Interface
Parameters:
- XLEN, 32: output width; legal values ≥ 32.
- STAGES, 1: register stages, 1 or 2; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  Instr/ImmSrc/CarryIn are valid this cycle.
- stall  in  1  freeze all stage registers.
- flush  in  1  kill all in-flight entries.
- Instr  in  24  instruction bits [23:0].
- ImmSrc  in  3  immediate form select.
- CarryIn  in  1  current C flag; passed through when no rotation occurs.
- out_valid  out  1  ExtImm/ImmCarry/ImmIllegal are valid.
- ExtImm  out  XLEN  extended immediate.
- ImmCarry  out  1  shifter carry-out for this immediate.
- ImmIllegal  out  1  ImmSrc was a reserved code.

## Operation
ImmSrc encodings, with rot = Instr[11:8], imm8 = Instr[7:0]:
- 3'b000 DP_ROT: 32-bit {24'b0, imm8} rotated right by 2·rot, zero-extended to XLEN. ImmCarry = result[31] if rot≠0, else CarryIn.
- 3'b001 MEM12: zero-extend Instr[11:0]. ImmCarry = CarryIn.
- 3'b010 BR: sign-extend {Instr[23:0], 2'b00} to XLEN. ImmCarry = CarryIn.
- 3'b011 MEMH: zero-extend {Instr[11:8], Instr[3:0]}. ImmCarry = CarryIn.
- 3'b100 DP_RAW: zero-extend imm8 with no rotation; this is the legacy form. ImmCarry = CarryIn.
- 3'b101–3'b111 are reserved: ExtImm = 0, ImmCarry = CarryIn, ImmIllegal = 1.

Rotation is always performed in 32 bits, independent of XLEN.

Each stage holds {valid, data}. Stage update priority, highest first:
1. reset: valid ← 0, all data ← 0.
2. flush: same as reset. Flush overrides stall.
3. stall: hold every stage.
4. Otherwise, advance the pipeline:
   - Stage 0 loads from the inputs with valid ← in_valid.
   - A stage loading a bubble (valid = 0) clears its data to 0.

Inputs presented while stall = 1 are not accepted. The producer must hold them.

For STAGES = 2:
- Stage A registers: mode, 32-bit pre-rotation value, rot, CarryIn, illegal flag.
- Stage B applies rotation and carry selection, then registers the final outputs.

For STAGES = 1, all of the work is done before the single register.

## Timing
- Latency is exactly STAGES cycles from an accepted in_valid to out_valid, counting only non-stalled cycles.
- Throughput is one immediate per cycle; there are no internal bubbles.
- All outputs are registered, with no combinational input→output path.
- Reset values: out_valid = 0, ExtImm = 0, ImmCarry = 0, ImmIllegal = 0.
- Reset asserted mid-operation discards all in-flight entries at that edge. out_valid is 0 from the next cycle.
- When stall and flush are asserted together, flush wins: outputs are 0 after the edge.
- Under stall, outputs stay bit-identical for every stalled cycle.
- The first accepted input after release of stall or reset appears after STAGES cycles.

## Structure
- Package imm_pkg holds:
  - ImmSrc localparams: IMM_DP_ROT, IMM_MEM12, IMM_BR, IMM_MEMH, IMM_DP_RAW.
  - Default XLEN.
  - A stage-record typedef/struct containing valid, value, rot, carry, illegal.
- Sub-module imm_rotator: combinational 32-bit rotate-right by {rot, 1'b0} that also produces carry = result[31] when rot≠0. It is instantiated once.

## Test plan
1. DP_ROT, Instr[11:0] = 12'h4FF, CarryIn = 0 → after STAGES cycles: ExtImm = 32'hFF000000, ImmCarry = 1, out_valid = 1.
2. DP_ROT with rot = 0, imm8 = 8'h80, CarryIn = 1 → ExtImm = 32'h00000080, ImmCarry = 1. Repeat with CarryIn = 0 → ImmCarry = 0.
3. One input per cycle, back-to-back:
   - MEM12 with 12'h123 → 32'h00000123.
   - BR with 24'hFFFFFE → 32'hFFFFFFF8.
   - MEMH with Instr[11:8] = 4'hA, Instr[3:0] = 4'h5 → 32'h000000A5.
   - Outputs arrive in order on consecutive cycles.
4. Reserved ImmSrc = 3'b111 → ExtImm = 0, ImmIllegal = 1, out_valid = 1.
5. Stall for 3 cycles with a valid entry in flight → outputs frozen, then resume with the correct value and no loss or duplication. Then assert flush together with stall → out_valid = 0 and data = 0 next cycle.
6. Assert reset mid-stream with 2 entries in flight (STAGES = 2) → all outputs 0 on the following cycle. Run the full suite at both STAGES = 1/2 and XLEN = 32/64; for the BR case at XLEN = 64, ExtImm = 64'hFFFFFFFFFFFFFFF8.
